div7_arbiter: RTL and testbench
===============================

Name: div7_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one div_7 divide-by-7 unit among N_REQ requesters.
- Selects a pending requester, captures its operand, issues a single start pulse and waits for the divider's valid pulse.
- Returns quotient/remainder tagged with the requester ID, then enforces the divider's one-cycle DONE recovery before the next issue.
- Also owns the divider's synchronous reset, plus a watchdog that flags a hung divider.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must equal ceil(log2(N_REQ)).
- TIMEOUT, 32, WAIT-state cycles before declaring the divider hung (must be >17).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester level request; held until matching ack
- req_data  in  16*N_REQ  packed operands; requester i uses bits [16*i+15:16*i]
- ack  out  N_REQ  one-cycle pulse: operand of requester i captured
- rsp_valid  out  1  one-cycle result pulse
- rsp_id  out  ID_W  requester owning the result
- rsp_q  out  14  quotient
- rsp_rem  out  4  remainder
- err  out  1  one-cycle pulse on watchdog timeout
- div_rst  out  1  active-high synchronous reset to div_7
- div_start  out  1  start pulse to div_7
- div_data  out  16  operand to div_7
- div_valid  in  1  div_7 valid pulse
- div_busy  in  1  div_7 busy

Behaviour:
- Reset: clk and rst_n form the single clock/reset domain. rst_n is asynchronous, active-low.
  - All outputs are registered and go 0 on reset, except div_rst, which goes 1.
  - Internal state on reset: state=IDLE, rr pointer=N_REQ-1, timer=0.
- div_rst: held 1 while rst_n is low and for 2 cycles after rst_n deasserts. This guarantees div_7 is in its IDLE state before the first issue. No grants occur while div_rst=1.
- States: IDLE, START, WAIT, DRAIN.
- IDLE:
  - Grant only when any req bit is set, div_busy=0 and div_rst=0.
  - Winner is the first set bit searching upward from (rr pointer+1) mod N_REQ, wrapping.
  - On grant: latch req_data slice into div_data and index into the ID register; pulse ack[winner] next cycle; set rr pointer=winner; go START.
- START: div_start=1 for exactly this one cycle with div_data stable; clear timer; go WAIT.
- WAIT:
  - Timer increments each cycle.
  - On div_valid=1: capture div_7 q/reminder into rsp_q/rsp_rem, set rsp_id from the ID register, pulse rsp_valid next cycle, go DRAIN.
  - If the timer reaches TIMEOUT first: pulse err, no rsp_valid, pulse div_rst for 1 cycle, go DRAIN.
  - div_valid and the timeout in the same cycle: div_valid wins.
- DRAIN: exactly 1 cycle (covers div_7 DONE), go IDLE. rsp_q/rsp_rem/rsp_id hold their values until the next result.
- Latency: the grant edge is E0 and div_7 samples start at E1. div_7 raises valid after E17; the arbiter samples it at E18. rsp_valid is therefore high in the cycle after E18 (18 cycles after the ack edge).
- Throughput: one operation per 20 cycles. The next grant can occur in the cycle after DRAIN.
- req bits dropped before ack are simply not granted. req held after ack is treated as a new request.
- div_valid outside WAIT is ignored. No second start is ever issued while in START/WAIT/DRAIN.
- Fairness: with all req held, grants rotate 0,1,2,3,0,... No requester waits more than N_REQ-1 operations.
- Asynchronous reset mid-operation aborts immediately. No rsp_valid or err is emitted for the aborted operation. div_rst then resynchronises div_7.
- Width rules:
  - 16-bit operands.
  - Quotient max 9362, fits 14 bits.
  - Remainder is always 0..6.

Test Plan:
- Reset, then req[0]=1 with data=100 -> ack[0] pulse; rsp_valid 18 cycles after ack with rsp_id=0, rsp_q=14, rsp_rem=2.
- Requester 2 data=65535 -> rsp_q=9362, rsp_rem=1. Requester 1 data=6 -> q=0, rem=6. data=49 -> q=7, rem=0. data=0 -> q=0, rem=0.
- All four req held with data 7,14,21,28 -> rsp_id order 0,1,2,3,0; results q=1,2,3,4, rem=0; rsp_valid spacing 20 cycles.
- Model div_valid stuck low -> err pulse TIMEOUT cycles after START, no rsp_valid, div_rst 1-cycle pulse, next request served normally.
- Drop rst_n during WAIT -> all outputs 0 immediately, div_rst=1; after release, div_rst stays 1 for 2 cycles, then a fresh request completes correctly with no stale response.
- div_busy forced 1 in IDLE with req pending -> no ack until div_busy=0.

Source files
------------

// File: rtl/div7_arbiter.sv
// div7_arbiter: round-robin arbiter and sequencer sharing one div_7 divide-by-7
// unit among N_REQ requesters. It grants one pending requester, captures that
// requester's operand, issues a single start pulse, waits for the divider's valid
// pulse and returns the result tagged with the requester ID. After each result it
// spends one DRAIN cycle so the divider can finish its DONE state. The block also
// owns the divider's synchronous reset and runs a watchdog that flags a hung divider.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req          per-requester level request, held until the matching ack
//   req_data     packed 16-bit operands; requester i uses [16*i+15:16*i]
//   ack          one-cycle pulse: operand of requester i captured
//   rsp_valid    one-cycle result pulse
//   rsp_id       requester that owns rsp_q/rsp_rem (held until the next result)
//   rsp_q        quotient (held)
//   rsp_rem      remainder (held)
//   err          one-cycle pulse when the watchdog expires
//   div_rst      active-high synchronous reset to div_7
//   div_start    start pulse to div_7
//   div_data     operand to div_7, stable while div_start is high
//   div_valid    div_7 result valid pulse
//   div_busy     div_7 busy
//   div_q        div_7 quotient, sampled when div_valid is high
//   div_rem      div_7 remainder, sampled when div_valid is high
module div7_arbiter #(
    parameter int unsigned  N_REQ   = 4,
    parameter int unsigned  ID_W    = 2,
    parameter int unsigned  TIMEOUT = 32,
    localparam int unsigned DATA_W  = 16,
    localparam int unsigned Q_W     = 14,
    localparam int unsigned REM_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [DATA_W*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]          ack,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [Q_W-1:0]            rsp_q,
    output logic [REM_W-1:0]          rsp_rem,
    output logic                      err,
    output logic                      div_rst,
    output logic                      div_start,
    output logic [DATA_W-1:0]         div_data,
    input  logic                      div_valid,
    input  logic                      div_busy,
    input  logic [Q_W-1:0]            div_q,
    input  logic [REM_W-1:0]          div_rem
);

    // Watchdog counts 0..TIMEOUT-1 WAIT cycles.
    localparam int unsigned TMR_W  = $clog2(TIMEOUT);
    // Post-reset hold of div_rst, in cycles.
    localparam int unsigned RCNT_W = 2;
    localparam int unsigned RST_HOLD = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_q, rr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [RCNT_W-1:0]   rst_cnt_q, rst_cnt_d;

    logic [N_REQ-1:0]    ack_q, ack_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [Q_W-1:0]      rsp_q_q, rsp_q_d;
    logic [REM_W-1:0]    rsp_rem_q, rsp_rem_d;
    logic                err_q, err_d;
    logic                div_rst_q, div_rst_d;
    logic                div_start_q, div_start_d;
    logic [DATA_W-1:0]   div_data_q, div_data_d;

    logic                hi_found, lo_found, win_found;
    logic [ID_W-1:0]     hi_idx, lo_idx, win_idx;
    logic [DATA_W-1:0]   win_data;

    // Round-robin search: lowest set bit above the pointer, else lowest set bit overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_found = 1'b1;
                lo_idx   = ID_W'(i);
                if (ID_W'(i) > rr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end
            end
        end
        win_found = lo_found;
        win_idx   = hi_found ? hi_idx : lo_idx;
    end

    // Operand slice of the winning requester.
    always_comb begin
        win_data = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (win_idx == ID_W'(i)) begin
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= ID_W'(N_REQ - 1);
            id_q        <= '0;
            timer_q     <= '0;
            rst_cnt_q   <= RCNT_W'(RST_HOLD);
            ack_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_q_q     <= '0;
            rsp_rem_q   <= '0;
            err_q       <= 1'b0;
            div_rst_q   <= 1'b1;
            div_start_q <= 1'b0;
            div_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            id_q        <= id_d;
            timer_q     <= timer_d;
            rst_cnt_q   <= rst_cnt_d;
            ack_q       <= ack_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_q_q     <= rsp_q_d;
            rsp_rem_q   <= rsp_rem_d;
            err_q       <= err_d;
            div_rst_q   <= div_rst_d;
            div_start_q <= div_start_d;
            div_data_q  <= div_data_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        id_d        = id_q;
        timer_d     = timer_q;
        rst_cnt_d   = rst_cnt_q;
        ack_d       = '0;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_q_d     = rsp_q_q;
        rsp_rem_d   = rsp_rem_q;
        err_d       = 1'b0;
        div_start_d = 1'b0;
        div_data_d  = div_data_q;

        // div_rst stays high for RST_HOLD cycles after reset release.
        div_rst_d = (rst_cnt_q != '0);
        if (rst_cnt_q != '0) begin
            rst_cnt_d = rst_cnt_q - RCNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (win_found && !div_busy && !div_rst_q) begin
                    ack_d       = N_REQ'(1) << win_idx;
                    rr_d        = win_idx;
                    id_d        = win_idx;
                    div_data_d  = win_data;
                    // div_start is registered, so it is high exactly during START.
                    div_start_d = 1'b1;
                    state_d     = START;
                end
            end
            START: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A result arriving on the timeout cycle still wins.
                if (div_valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_q_d     = div_q;
                    rsp_rem_d   = div_rem;
                    state_d     = DRAIN;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    err_d     = 1'b1;
                    div_rst_d = 1'b1;
                    state_d   = DRAIN;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ack       = ack_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_q     = rsp_q_q;
    assign rsp_rem   = rsp_rem_q;
    assign err       = err_q;
    assign div_rst   = div_rst_q;
    assign div_start = div_start_q;
    assign div_data  = div_data_q;

endmodule

// File: tb/tb_div7_arbiter.sv
// Testbench for div7_arbiter: behavioural div_7 stand-in, a timeline reference
// model compared every cycle, and directed scenarios with literal expectations.
module tb_div7_arbiter;

    localparam int unsigned N_REQ   = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned TIMEOUT = 32;

    logic                  clk      = 1'b0;
    logic                  rst_n    = 1'b0;
    logic [N_REQ-1:0]      req      = '0;
    logic [16*N_REQ-1:0]   req_data = '0;
    logic [N_REQ-1:0]      ack;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [13:0]           rsp_q;
    logic [3:0]            rsp_rem;
    logic                  err;
    logic                  div_rst;
    logic                  div_start;
    logic [15:0]           div_data;
    logic                  div_valid = 1'b0;
    logic                  div_busy;
    logic [13:0]           div_q     = '0;
    logic [3:0]            div_rem   = '0;

    // div_7 stand-in state
    logic                  dbusy = 1'b0;
    int                    dcnt  = 0;
    logic [15:0]           dop   = '0;
    bit                    stuck      = 1'b0;
    bit                    force_busy = 1'b0;
    bit                    hold_all   = 1'b0;
    bit                    chk_on     = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    assign div_busy = dbusy | force_busy;

    div7_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_q     (rsp_q),
        .rsp_rem   (rsp_rem),
        .err       (err),
        .div_rst   (div_rst),
        .div_start (div_start),
        .div_data  (div_data),
        .div_valid (div_valid),
        .div_busy  (div_busy),
        .div_q     (div_q),
        .div_rem   (div_rem)
    );

    // div_7 stand-in: samples start, valid pulse after 16 more edges, busy drops with valid.
    always @(posedge clk) begin
        if (div_rst === 1'b1) begin
            dcnt      <= 0;
            dbusy     <= 1'b0;
            div_valid <= 1'b0;
        end else begin
            div_valid <= 1'b0;
            if (!dbusy && div_start === 1'b1) begin
                dbusy <= 1'b1;
                dcnt  <= 1;
                dop   <= div_data;
            end else if (dbusy) begin
                if (dcnt == 16 && !stuck) begin
                    div_valid <= 1'b1;
                    div_q     <= 14'(dop / 16'd7);
                    div_rem   <= 4'(dop % 16'd7);
                    dcnt      <= 17;
                end else if (dcnt == 17 && !stuck) begin
                    dbusy <= 1'b0;
                    dcnt  <= 0;
                end else if (dcnt < 17) begin
                    dcnt <= dcnt + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an operation is a timeline measured in edges since its grant.
    bit                m_active = 1'b0;
    bit                m_pulse  = 1'b0;
    bit                m_found  = 1'b0;
    int                m_age = 0, m_rsp_at = 0, m_err_at = 0, m_free_at = 0;
    int                m_rr = N_REQ - 1, m_hold = 2, m_w = 0, m_c = 0;
    logic [15:0]       m_data = '0;
    logic [N_REQ-1:0]  e_ack = '0;
    logic              e_rsp_valid = 1'b0, e_err = 1'b0, e_div_rst = 1'b1, e_div_start = 1'b0;
    logic [ID_W-1:0]   e_rsp_id = '0;
    logic [13:0]       e_q = '0;
    logic [3:0]        e_rem = '0;
    logic [15:0]       e_div_data = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_rr = N_REQ - 1;
            m_hold = 2;
            e_ack = '0; e_rsp_valid = 1'b0; e_err = 1'b0; e_div_rst = 1'b1; e_div_start = 1'b0;
            e_rsp_id = '0; e_q = '0; e_rem = '0; e_div_data = '0;
        end else begin
            e_ack = '0; e_rsp_valid = 1'b0; e_err = 1'b0; e_div_start = 1'b0;
            m_pulse = 1'b0;
            if (m_active) begin
                m_age++;
                if (m_age == m_rsp_at) begin
                    e_rsp_valid = 1'b1;
                    e_rsp_id    = ID_W'(m_w);
                    e_q         = 14'(m_data / 7);
                    e_rem       = 4'(m_data % 7);
                end
                if (m_age == m_err_at) begin
                    e_err   = 1'b1;
                    m_pulse = 1'b1;
                end
                if (m_age == m_free_at) m_active = 1'b0;
            end
            if (!m_active && req != '0 && !div_busy && !e_div_rst) begin
                m_found = 1'b0;
                for (int k = 1; k <= int'(N_REQ); k++) begin
                    m_c = (m_rr + k) % int'(N_REQ);
                    if (!m_found && req[m_c]) begin
                        m_found = 1'b1;
                        m_w     = m_c;
                    end
                end
                m_active     = 1'b1;
                m_age        = 0;
                m_rr         = m_w;
                m_data       = req_data[16*m_w +: 16];
                e_ack[m_w]   = 1'b1;
                e_div_start  = 1'b1;
                e_div_data   = m_data;
                if (stuck) begin
                    m_rsp_at  = -1;
                    m_err_at  = TIMEOUT + 1;
                    m_free_at = TIMEOUT + 3;
                end else begin
                    m_rsp_at  = 18;
                    m_err_at  = -1;
                    m_free_at = 20;
                end
            end
            e_div_rst = (m_hold > 0) || m_pulse;
            if (m_hold > 0) m_hold--;
        end
    end

    // Every-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            check("cyc_ack",       32'(ack),       32'(e_ack));
            check("cyc_rsp_valid", 32'(rsp_valid), 32'(e_rsp_valid));
            check("cyc_rsp_id",    32'(rsp_id),    32'(e_rsp_id));
            check("cyc_rsp_q",     32'(rsp_q),     32'(e_q));
            check("cyc_rsp_rem",   32'(rsp_rem),   32'(e_rem));
            check("cyc_err",       32'(err),       32'(e_err));
            check("cyc_div_rst",   32'(div_rst),   32'(e_div_rst));
            check("cyc_div_start", 32'(div_start), 32'(e_div_start));
            check("cyc_div_data",  32'(div_data),  32'(e_div_data));
        end
    end

    // One cycle; requesters drop their request once acknowledged unless told to hold.
    task automatic tick();
        @(negedge clk);
        if (!hold_all) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (ack[i]) req[i] = 1'b0;
            end
        end
    endtask

    // One request from requester id; checks ack-to-result latency and the result.
    task automatic serve(input int id, input logic [15:0] data, input int eq, input int er);
        int t_ack, t_rsp;
        logic [ID_W-1:0] g_id;
        logic [13:0]     g_q;
        logic [3:0]      g_rem;
        t_ack = -1; t_rsp = -1; g_id = '0; g_q = '0; g_rem = '0;
        req_data[16*id +: 16] = data;
        req[id] = 1'b1;
        for (int t = 0; t < 80 && t_rsp < 0; t++) begin
            tick();
            if (t_ack < 0 && ack[id]) t_ack = t;
            if (rsp_valid) begin
                t_rsp = t; g_id = rsp_id; g_q = rsp_q; g_rem = rsp_rem;
            end
        end
        check("serve_latency", 32'(t_rsp - t_ack), 32'd18);
        check("serve_id",      32'(g_id),  32'(id));
        check("serve_q",       32'(g_q),   32'(eq));
        check("serve_rem",     32'(g_rem), 32'(er));
    endtask

    initial begin
        int n, t_ack, t_err, n_rsp, n_rst, n_err, n_ack;
        int ids[5], qs[5], rems[5], times[5];

        // Reset values
        rst_n = 1'b0;
        repeat (3) tick();
        chk_on = 1'b1;
        tick();
        check("rst_ack",       32'(ack),       32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_err",       32'(err),       32'd0);
        check("rst_div_start", 32'(div_start), 32'd0);
        check("rst_div_rst",   32'(div_rst),   32'd1);
        rst_n = 1'b1;
        tick(); check("div_rst_hold1",   32'(div_rst), 32'd1);
        tick(); check("div_rst_hold2",   32'(div_rst), 32'd1);
        tick(); check("div_rst_release", 32'(div_rst), 32'd0);

        // Fairness: all four held, operands 7,14,21,28
        hold_all = 1'b1;
        for (int i = 0; i < int'(N_REQ); i++) req_data[16*i +: 16] = 16'(7 * (i + 1));
        req = '1;
        n = 0;
        for (int t = 0; t < 200 && n < 5; t++) begin
            tick();
            if (rsp_valid) begin
                ids[n] = int'(rsp_id); qs[n] = int'(rsp_q); rems[n] = int'(rsp_rem); times[n] = t;
                n++;
            end
        end
        req = '0;
        hold_all = 1'b0;
        check("rr_count", 32'(n), 32'd5);
        for (int k = 0; k < n; k++) begin
            check("rr_id",  32'(ids[k]),  32'(k % 4));
            check("rr_q",   32'(qs[k]),   32'(k % 4 + 1));
            check("rr_rem", 32'(rems[k]), 32'd0);
            if (k > 0) check("rr_spacing", 32'(times[k] - times[k-1]), 32'd20);
        end
        repeat (4) tick();

        // Single operations with boundary operands
        serve(0, 16'd100,   14,   2);
        serve(2, 16'd65535, 9362, 1);
        serve(1, 16'd6,     0,    6);
        serve(1, 16'd49,    7,    0);
        serve(1, 16'd0,     0,    0);

        // div_busy held high blocks grants
        force_busy = 1'b1;
        req_data[16*3 +: 16] = 16'd700;
        req[3] = 1'b1;
        n_ack = 0;
        for (int t = 0; t < 12; t++) begin
            tick();
            if (ack != '0) n_ack++;
        end
        check("busy_no_ack", 32'(n_ack), 32'd0);
        force_busy = 1'b0;
        serve(3, 16'd700, 100, 0);

        // Hung divider: watchdog
        stuck = 1'b1;
        req_data[16*2 +: 16] = 16'd50;
        req[2] = 1'b1;
        t_ack = -1; t_err = -1; n_rsp = 0; n_rst = 0; n_err = 0;
        for (int t = 0; t < int'(TIMEOUT) + 10; t++) begin
            tick();
            if (t_ack < 0 && ack[2]) t_ack = t;
            if (err) begin n_err++; if (t_err < 0) t_err = t; end
            if (rsp_valid) n_rsp++;
            if (div_rst) n_rst++;
        end
        stuck = 1'b0;
        check("wd_err_latency", 32'(t_err - t_ack), 32'(TIMEOUT + 1));
        check("wd_err_pulses",  32'(n_err), 32'd1);
        check("wd_no_rsp",      32'(n_rsp), 32'd0);
        check("wd_div_rst_len", 32'(n_rst), 32'd1);
        serve(3, 16'd20, 2, 6);

        // Reset during WAIT
        req_data[15:0] = 16'd1000;
        req[0] = 1'b1;
        t_ack = -1;
        for (int t = 0; t < 10 && t_ack < 0; t++) begin
            tick();
            if (ack[0]) t_ack = t;
        end
        check("abort_ack_seen", 32'(t_ack >= 0), 32'd1);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_err",       32'(err),       32'd0);
        check("abort_div_data",  32'(div_data),  32'd0);
        check("abort_rsp_q",     32'(rsp_q),     32'd0);
        check("abort_div_rst",   32'(div_rst),   32'd1);
        repeat (3) tick();
        rst_n = 1'b1;
        n_rsp = 0;
        tick(); check("abort_hold1", 32'(div_rst), 32'd1); if (rsp_valid) n_rsp++;
        tick(); check("abort_hold2", 32'(div_rst), 32'd1); if (rsp_valid) n_rsp++;
        tick(); check("abort_rel",   32'(div_rst), 32'd0); if (rsp_valid) n_rsp++;
        check("abort_no_stale", 32'(n_rsp), 32'd0);
        serve(0, 16'd777, 111, 0);

        repeat (5) tick();
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
